// File: rtl/tmds_decoder.sv
// TMDS receive channel decoder.
// Finds symbol alignment in a free-running 10-bit deserialized stream by hunting
// for runs of control tokens, then decodes each aligned symbol into either an
// 8-bit video byte or the 2-bit control value carried by a token.
module tmds_decoder #(
  parameter int unsigned SEARCH_TIMEOUT = 2048,
  parameter int unsigned LOCK_TOKENS    = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] sym_i,
  output logic [7:0] data_o,
  output logic       de_o,
  output logic [1:0] ctrl_o,
  output logic       locked_o,
  output logic [3:0] offset_o
);

  localparam int unsigned IDLE_W = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int unsigned TOK_W  = $clog2(LOCK_TOKENS) + 1;

  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(SEARCH_TIMEOUT);
  localparam logic [TOK_W-1:0]  TOK_MAX  = TOK_W'(LOCK_TOKENS);
  localparam logic [3:0]        OFS_LAST = 4'd9;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e            state_q,   state_d;
  logic [9:0]        sym_q;
  logic [3:0]        offset_q,  offset_d;
  logic [TOK_W-1:0]  tok_run_q, tok_run_d;
  logic [IDLE_W-1:0] idle_q,    idle_d;
  logic [7:0]        data_q,    data_d;
  logic              de_q,      de_d;
  logic [1:0]        ctrl_q,    ctrl_d;

  logic [19:0]       window;
  logic [9:0]        word;
  logic              is_tok;
  logic [1:0]        tok_c;
  logic [7:0]        q_bits;
  logic [7:0]        dec;
  logic [TOK_W-1:0]  tok_sat;
  logic [IDLE_W-1:0] idle_sat;
  logic              hit_lock;
  logic              hit_timeout;

  // Bit 0 of the window is the oldest received bit, so the previous word sits low.
  assign window = {sym_i, sym_q};

  // Pick the 10-bit symbol starting at the current alignment offset.
  always_comb begin
    word = 10'(window >> offset_q);
  end

  // Recognise the four control tokens and the control value each carries.
  always_comb begin
    is_tok = 1'b0;
    tok_c  = 2'b00;
    unique case (word)
      10'b1101010100: begin is_tok = 1'b1; tok_c = 2'b00; end
      10'b0010101011: begin is_tok = 1'b1; tok_c = 2'b01; end
      10'b0101010100: begin is_tok = 1'b1; tok_c = 2'b10; end
      10'b1010101011: begin is_tok = 1'b1; tok_c = 2'b11; end
      default:        begin is_tok = 1'b0; tok_c = 2'b00; end
    endcase
  end

  // Undo the DC-balance inversion (bit 9) and the XOR/XNOR transition coding (bit 8).
  always_comb begin
    q_bits = word[9] ? ~word[7:0] : word[7:0];
    dec    = '0;
    dec[0] = q_bits[0];
    for (int unsigned i = 1; i < 8; i++) begin
      dec[i] = word[8] ? (q_bits[i] ^ q_bits[i-1]) : ~(q_bits[i] ^ q_bits[i-1]);
    end
  end

  // Saturating token-run and idle counters, before any FSM-driven clearing.
  always_comb begin
    tok_sat  = '0;
    idle_sat = '0;
    if (is_tok) begin
      tok_sat  = (tok_run_q == TOK_MAX) ? TOK_MAX : tok_run_q + TOK_W'(1);
      idle_sat = '0;
    end else begin
      tok_sat  = '0;
      idle_sat = (idle_q == IDLE_MAX) ? IDLE_MAX : idle_q + IDLE_W'(1);
    end
  end

  assign hit_lock    = (tok_sat == TOK_MAX);
  assign hit_timeout = (idle_sat == IDLE_MAX);

  // Next-state logic for alignment search/lock, counters and offset.
  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    tok_run_d = tok_sat;
    idle_d    = idle_sat;
    unique case (state_q)
      ST_SEARCH: begin
        if (hit_lock) begin
          state_d = ST_LOCKED;
        end else if (hit_timeout) begin
          offset_d  = (offset_q == OFS_LAST) ? 4'd0 : offset_q + 4'd1;
          tok_run_d = '0;
          idle_d    = '0;
        end
      end
      ST_LOCKED: begin
        // Offset is kept on lock loss; the first step happens on the next search timeout.
        if (hit_timeout) begin
          state_d   = ST_SEARCH;
          tok_run_d = '0;
          idle_d    = '0;
        end
      end
      default: begin
        state_d   = ST_SEARCH;
        tok_run_d = '0;
        idle_d    = '0;
      end
    endcase
  end

  // Output selection follows the state being entered, so the locking token and the
  // lock-loss cycle already use the new state's output rule.
  always_comb begin
    data_d = '0;
    de_d   = 1'b0;
    ctrl_d = ctrl_q;
    if (state_d == ST_LOCKED) begin
      if (is_tok) begin
        ctrl_d = tok_c;
      end else begin
        de_d   = 1'b1;
        data_d = dec;
      end
    end else begin
      ctrl_d = '0;
    end
  end

  // State, counter, offset and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_SEARCH;
      sym_q     <= '0;
      offset_q  <= '0;
      tok_run_q <= '0;
      idle_q    <= '0;
      data_q    <= '0;
      de_q      <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      sym_q     <= sym_i;
      offset_q  <= offset_d;
      tok_run_q <= tok_run_d;
      idle_q    <= idle_d;
      data_q    <= data_d;
      de_q      <= de_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign data_o   = data_q;
  assign de_o     = de_q;
  assign ctrl_o   = ctrl_q;
  assign locked_o = (state_q == ST_LOCKED);
  assign offset_o = offset_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: a cycle model predicts every registered output and a
// scoreboard compares them each clock; scenario tasks add targeted checks.
module tb_tmds_decoder;

  localparam int TO = 16;
  localparam int LT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sym = '0;
  logic [7:0] data;
  logic       de;
  logic [1:0] ctrl;
  logic       locked;
  logic [3:0] offset;

  tmds_decoder #(.SEARCH_TIMEOUT(TO), .LOCK_TOKENS(LT)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .sym_i    (sym),
    .data_o   (data),
    .de_o     (de),
    .ctrl_o   (ctrl),
    .locked_o (locked),
    .offset_o (offset)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;

  typedef struct packed {
    logic       lock;
    logic [3:0] off;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // reference model state
  bit         m_lock;
  int         m_off, m_tok, m_idle;
  logic [9:0] m_symq;
  logic [1:0] m_ctrl;

  // serial stream generator: rot = bit slip of the deserializer word boundary
  int         rot = 0;
  logic [9:0] prev_s = 10'h100;
  bit         vid_t = 1'b0;

  function automatic int tok_code(input logic [9:0] w);
    case (w)
      10'h354: return 0;
      10'h0AB: return 1;
      10'h154: return 2;
      10'h2AB: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] tmds_dec(input logic [9:0] w);
    logic [7:0] q, d;
    q = w[7:0];
    if (w[9]) q = ~q;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = (q[i] ^ q[i-1]) ^ ~w[8];
    return d;
  endfunction

  task automatic model_reset();
    m_lock = 0; m_off = 0; m_tok = 0; m_idle = 0; m_symq = '0; m_ctrl = '0;
    sb.delete();
  endtask

  task automatic model_step(input logic [9:0] s);
    logic [19:0] win;
    logic [9:0]  w;
    int          c;
    exp_t        e;
    win = {s, m_symq};
    w   = 10'(win >> m_off);
    c   = tok_code(w);
    if (c >= 0) begin
      m_tok  = (m_tok < LT) ? m_tok + 1 : LT;
      m_idle = 0;
    end else begin
      m_tok  = 0;
      m_idle = (m_idle < TO) ? m_idle + 1 : TO;
    end
    if (!m_lock) begin
      if (m_tok == LT) m_lock = 1;
      else if (m_idle == TO) begin
        m_off = (m_off + 1) % 10; m_tok = 0; m_idle = 0;
      end
    end else if (m_idle == TO) begin
      m_lock = 0; m_tok = 0; m_idle = 0;
    end
    e.lock = m_lock;
    e.off  = 4'(m_off);
    if (m_lock) begin
      if (c >= 0) begin e.de = 0; e.data = '0; m_ctrl = 2'(c); end
      else begin e.de = 1; e.data = tmds_dec(w); end
    end else begin
      e.de = 0; e.data = '0; m_ctrl = '0;
    end
    e.ctrl = m_ctrl;
    m_symq = s;
    sb.push_back(e);
  endtask

  // drive one raw word, predict, then wait until just after the edge
  task automatic cycle(input logic [9:0] word);
    sym = word;
    model_step(word);
    @(posedge clk);
    #2;
  endtask

  // send one symbol through the bit-slipped stream
  task automatic send(input logic [9:0] s);
    logic [9:0] word;
    word   = 10'({s, prev_s} >> (10 - rot));
    prev_s = s;
    cycle(word);
  endtask

  task automatic send_video();
    send(vid_t ? 10'h2FF : 10'h100);
    vid_t = ~vid_t;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    sym = '0;
    model_reset();
    prev_s = 10'h100;
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b0;
  endtask

  // scoreboard: compare every predicted output word one step after its edge
  initial forever begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      tests_run++;
      if ({locked, offset, de, data, ctrl} !== mon_e) begin
        fails++;
        $display("FAIL scoreboard @%0t got lock=%b off=%0d de=%b data=%h ctrl=%b expected lock=%b off=%0d de=%b data=%h ctrl=%b",
                 $time, locked, offset, de, data, ctrl,
                 mon_e.lock, mon_e.off, mon_e.de, mon_e.data, mon_e.ctrl);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; sym = '0; rot = 0; prev_s = 10'h100;
    model_reset();
    @(posedge clk);
    #1;
    tests_run++;
    if ({locked, offset, de, data, ctrl} !== 16'h0) begin
      fails++; $display("FAIL reset_hold outputs=%h expected 0000", {locked, offset, de, data, ctrl});
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({locked, offset, de, data, ctrl} !== 16'h0) begin
      fails++; $display("FAIL reset_release outputs=%h expected 0000", {locked, offset, de, data, ctrl});
    end
  endtask

  task automatic test_aligned();
    rot = 0;
    for (int i = 0; i < 8; i++) send(10'h354);
    tests_run++;
    if (locked !== 1'b0) begin fails++; $display("FAIL aligned_7tok locked=%b expected 0", locked); end
    send(10'h100);
    tests_run++;
    if (locked !== 1'b1 || offset !== 4'd0 || de !== 1'b0 || ctrl !== 2'b00) begin
      fails++; $display("FAIL aligned_lock locked=%b off=%0d de=%b ctrl=%b expected 1/0/0/00", locked, offset, de, ctrl);
    end
    send(10'h2FF);
    tests_run++;
    if (de !== 1'b1 || data !== 8'h00) begin fails++; $display("FAIL aligned_d0 de=%b data=%h expected 1/00", de, data); end
    send(10'h100);
    tests_run++;
    if (de !== 1'b1 || data !== 8'hFE) begin fails++; $display("FAIL aligned_d1 de=%b data=%h expected 1/fe", de, data); end
  endtask

  task automatic test_ctrl();
    send(10'h0AB);
    send(10'h154);
    tests_run++;
    if (de !== 1'b0 || ctrl !== 2'b01) begin fails++; $display("FAIL ctrl_01 de=%b ctrl=%b expected 0/01", de, ctrl); end
    send(10'h2AB);
    tests_run++;
    if (de !== 1'b0 || ctrl !== 2'b10) begin fails++; $display("FAIL ctrl_10 de=%b ctrl=%b expected 0/10", de, ctrl); end
    send(10'h100);
    tests_run++;
    if (de !== 1'b0 || ctrl !== 2'b11) begin fails++; $display("FAIL ctrl_11 de=%b ctrl=%b expected 0/11", de, ctrl); end
    send(10'h2FF);
    tests_run++;
    if (de !== 1'b1 || ctrl !== 2'b11 || data !== 8'h00) begin
      fails++; $display("FAIL ctrl_hold de=%b ctrl=%b data=%h expected 1/11/00", de, ctrl, data);
    end
  endtask

  task automatic test_hold();
    send(10'h354);
    for (int i = 0; i < TO - 1; i++) send_video();
    tests_run++;
    if (locked !== 1'b1) begin fails++; $display("FAIL hold_idle15 locked=%b expected 1", locked); end
    send(10'h2AB);
    send(10'h100);
    tests_run++;
    if (locked !== 1'b1 || de !== 1'b0 || ctrl !== 2'b11) begin
      fails++; $display("FAIL hold_retained locked=%b de=%b ctrl=%b expected 1/0/11", locked, de, ctrl);
    end
    for (int i = 0; i < TO - 1; i++) send_video();
    tests_run++;
    if (locked !== 1'b1 || ctrl !== 2'b11) begin
      fails++; $display("FAIL hold_edge locked=%b ctrl=%b expected 1/11", locked, ctrl);
    end
    send_video();
    tests_run++;
    if (locked !== 1'b0 || de !== 1'b0 || ctrl !== 2'b00 || data !== 8'h00) begin
      fails++; $display("FAIL hold_drop locked=%b de=%b ctrl=%b data=%h expected 0/0/00/00", locked, de, ctrl, data);
    end
  endtask

  // walk the offset from 0 up to 'target', one step per search timeout
  task automatic walk_offset(input int target);
    int n;
    for (int step = 1; step <= target; step++) begin
      for (int i = 0; i < 8; i++) send(10'h354);
      n = 0;
      while (m_off != step && n < 64) begin send_video(); n++; end
      tests_run++;
      if (offset !== 4'(step) || locked !== 1'b0) begin
        fails++; $display("FAIL walk_step%0d off=%0d locked=%b expected %0d/0", step, offset, locked, step);
      end
    end
  endtask

  task automatic test_rot3();
    reset_dut();
    rot = 3;
    walk_offset(3);
    for (int i = 0; i < 8; i++) send(10'h354);
    send(10'h100);
    tests_run++;
    if (locked !== 1'b1 || offset !== 4'd3) begin
      fails++; $display("FAIL rot3_lock locked=%b off=%0d expected 1/3", locked, offset);
    end
    send(10'h2FF);
    tests_run++;
    if (de !== 1'b1 || data !== 8'h00) begin fails++; $display("FAIL rot3_d0 de=%b data=%h expected 1/00", de, data); end
    send(10'h100);
    tests_run++;
    if (de !== 1'b1 || data !== 8'hFE) begin fails++; $display("FAIL rot3_d1 de=%b data=%h expected 1/fe", de, data); end
  endtask

  task automatic test_async_reset();
    send(10'h2FF);
    #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({locked, offset, de, data, ctrl} !== 16'h0) begin
      fails++; $display("FAIL async_reset outputs=%h expected 0000", {locked, offset, de, data, ctrl});
    end
    model_reset();
    @(posedge clk);
    #1;
    tests_run++;
    if ({locked, offset, de, data, ctrl} !== 16'h0) begin
      fails++; $display("FAIL async_reset_edge outputs=%h expected 0000", {locked, offset, de, data, ctrl});
    end
    #3;
    rst = 1'b0;
    rot = 0;
    for (int i = 0; i < 8; i++) send(10'h354);
    tests_run++;
    if (locked !== 1'b0) begin fails++; $display("FAIL reacq_early locked=%b expected 0", locked); end
    send(10'h100);
    tests_run++;
    if (locked !== 1'b1 || offset !== 4'd0) begin
      fails++; $display("FAIL reacq_lock locked=%b off=%0d expected 1/0", locked, offset);
    end
  endtask

  task automatic test_rot9_wrap();
    reset_dut();
    rot = 9;
    walk_offset(9);
    for (int i = 0; i < 8; i++) send(10'h354);
    send(10'h100);
    tests_run++;
    if (locked !== 1'b1 || offset !== 4'd9) begin
      fails++; $display("FAIL rot9_lock locked=%b off=%0d expected 1/9", locked, offset);
    end
    send(10'h2FF);
    tests_run++;
    if (de !== 1'b1 || data !== 8'h00) begin fails++; $display("FAIL rot9_d0 de=%b data=%h expected 1/00", de, data); end
    rot = 0;
    for (int i = 0; i < TO - 2; i++) send_video();
    tests_run++;
    if (locked !== 1'b1) begin fails++; $display("FAIL rot9_keep locked=%b expected 1", locked); end
    send_video();
    tests_run++;
    if (locked !== 1'b0 || offset !== 4'd9 || de !== 1'b0 || ctrl !== 2'b00) begin
      fails++; $display("FAIL rot9_loss locked=%b off=%0d de=%b ctrl=%b expected 0/9/0/00", locked, offset, de, ctrl);
    end
    for (int i = 0; i < TO - 1; i++) send_video();
    tests_run++;
    if (offset !== 4'd9) begin fails++; $display("FAIL wrap_pre off=%0d expected 9", offset); end
    send_video();
    tests_run++;
    if (offset !== 4'd0 || locked !== 1'b0) begin
      fails++; $display("FAIL wrap off=%0d locked=%b expected 0/0", offset, locked);
    end
    for (int i = 0; i < 8; i++) send(10'h354);
    send(10'h2FF);
    tests_run++;
    if (locked !== 1'b1 || offset !== 4'd0) begin
      fails++; $display("FAIL wrap_lock locked=%b off=%0d expected 1/0", locked, offset);
    end
    send(10'h100);
    tests_run++;
    if (de !== 1'b1 || data !== 8'hFE) begin fails++; $display("FAIL wrap_data de=%b data=%h expected 1/fe", de, data); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_aligned();
    test_ctrl();
    test_hold();
    test_rot3();
    test_async_reset();
    test_rot9_wrap();
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
